// File: rtl/fpmul_arbiter.sv
// fpmul_arbiter: round-robin sharing of one non-pipelined binary64 multiplier with a result watchdog
module fpmul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [64*NUM_REQ-1:0] req_a,
  input  logic [64*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [63:0]           resp_data,
  output logic                  resp_timeout,
  output logic                  busy,
  output logic [63:0]           mul_a,
  output logic [63:0]           mul_b,
  output logic                  mul_ready_in,
  input  logic [63:0]           mul_out,
  input  logic                  mul_ready_out
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] last_q, last_d, grant, cand;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rdy_prev_q, rise;
  logic [63:0] sel_a, sel_b;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
  logic [63:0] resp_data_q, resp_data_d, mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic resp_timeout_q, resp_timeout_d, busy_q, busy_d, mul_ready_in_q, mul_ready_in_d;
  // pick the first pending requester after the last one served, wrapping around
  always_comb begin
    grant = last_q;
    cand = last_q;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(last_q) + k) % NUM_REQ);
      if (req_valid[cand]) grant = cand;
    end
  end
  // route the granted requester's operands toward the multiplier
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant == IW'(k)) begin
        sel_a = req_a[64*k +: 64];
        sel_b = req_b[64*k +: 64];
      end
    end
  end
  // completion is a fresh rising ready_out, ignored while the operation is still being issued
  assign rise = mul_ready_out & ~rdy_prev_q & ~mul_ready_in_q;
  // sequencer: next state, watchdog counter and next values of all registered outputs
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    cnt_d = cnt_q;
    req_ready_d = '0;
    resp_valid_d = '0;
    mul_ready_in_d = 1'b0;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    resp_data_d = resp_data_q;
    resp_timeout_d = resp_timeout_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = WAIT;
          last_d = grant;
          cnt_d = '0;
          mul_a_d = sel_a;
          mul_b_d = sel_b;
          req_ready_d = NUM_REQ'(1) << grant;
          mul_ready_in_d = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = (mul_ready_in_q || cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
        if (rise || cnt_q == CW'(TIMEOUT)) begin
          state_d = RESP;
          resp_valid_d = NUM_REQ'(1) << last_q;
          resp_data_d = rise ? mul_out : QNAN;
          resp_timeout_d = ~rise;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end
  // state and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q <= IW'(NUM_REQ - 1);
      cnt_q <= '0;
      rdy_prev_q <= 1'b0;
      req_ready_q <= '0;
      resp_valid_q <= '0;
      resp_data_q <= '0;
      resp_timeout_q <= 1'b0;
      busy_q <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      mul_ready_in_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      rdy_prev_q <= mul_ready_out;
      req_ready_q <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q <= resp_data_d;
      resp_timeout_q <= resp_timeout_d;
      busy_q <= busy_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      mul_ready_in_q <= mul_ready_in_d;
    end
  end
  assign req_ready = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data = resp_data_q;
  assign resp_timeout = resp_timeout_q;
  assign busy = busy_q;
  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;
  assign mul_ready_in = mul_ready_in_q;
endmodule
